// File: rtl/thor2024_icache_line_fill_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : thor2024_icache_line_fill_pkg                              |
// | Brief   : shared types and I-cache geometry for the line-fill engine |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package thor2024_icache_line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } icfill_state_t;

    localparam int ICacheBundleWidth    = 128;
    localparam int ICacheLineWidth      = 512;
    localparam int ICacheBundles        = ICacheLineWidth / ICacheBundleWidth;
    localparam int ICacheBundleOffsBits = $clog2(ICacheBundleWidth / 8);

endpackage

`default_nettype wire

// File: rtl/thor2024_icache_line_fill_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : thor2024_icache_line_fill_if                               |
// | Brief   : fill-engine to bus-interface-unit read beat channel        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface thor2024_icache_line_fill_if
    import thor2024_icache_line_fill_pkg::*;
#(
    parameter int AWID         = 32,
    parameter int BUNDLE_WIDTH = ICacheBundleWidth
);
    logic                    req;
    logic [AWID-1:0]         req_adr;
    logic                    ack;
    logic                    err;
    logic [BUNDLE_WIDTH-1:0] dat;

    modport master (output req, req_adr, input ack, err, dat);
    modport slave  (input req, req_adr, output ack, err, dat);
endinterface

`default_nettype wire

// File: rtl/thor2024_icache_line_fill_bundle_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : thor2024_bundle_buf                                        |
// | Brief   : line buffer written one bundle at a time, per-bundle valid |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module thor2024_bundle_buf #(
    parameter int BUNDLE_WIDTH = 128,
    parameter int BUNDLES      = 4
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    input  wire logic                            clr_i,
    input  wire logic                            wr_i,
    input  wire logic [$clog2(BUNDLES)-1:0]      idx_i,
    input  wire logic [BUNDLE_WIDTH-1:0]         dat_i,
    output logic      [BUNDLE_WIDTH*BUNDLES-1:0] line_o,
    output logic      [BUNDLES-1:0]              valid_o
);
    localparam int IDX_BITS = $clog2(BUNDLES);

    for (genvar i = 0; i < BUNDLES; i++) begin : g_bundle
        logic [BUNDLE_WIDTH-1:0] data_q;
        logic                    valid_q;

        // Clear only drops valid; data is simply overwritten by the next fill.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (clr_i) begin
                valid_q <= 1'b0;
            end else if (wr_i && (idx_i == IDX_BITS'(i))) begin
                data_q  <= dat_i;
                valid_q <= 1'b1;
            end
        end

        assign line_o[i*BUNDLE_WIDTH +: BUNDLE_WIDTH] = data_q;
        assign valid_o[i]                             = valid_q;
    end
endmodule

`default_nettype wire

// File: rtl/thor2024_icache_line_fill.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : thor2024_icache_line_fill                                  |
// | Brief   : I-cache miss fill engine, critical bundle forwarded early  |
// |           THOR2024_ICFILL_CWF_EN selects critical-word-first order   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module thor2024_icache_line_fill
    import thor2024_icache_line_fill_pkg::*;
#(
    parameter int AWID         = 32,
    parameter int ASID_WIDTH   = 16,
    parameter int BUNDLE_WIDTH = ICacheBundleWidth,
    parameter int BUNDLES      = ICacheBundles
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    input  wire logic                            miss_i,
    input  wire logic [AWID-1:0]                 miss_adr_i,
    input  wire logic [ASID_WIDTH-1:0]           miss_asid_i,
    input  wire logic                            abort_i,
    output logic                                 ready_o,
    thor2024_icache_line_fill_if.master          bus,
    output logic                                 crit_v_o,
    output logic      [BUNDLE_WIDTH-1:0]         crit_dat_o,
    output logic      [BUNDLES-1:0]              bundle_v_o,
    output logic                                 line_wr_o,
    output logic      [BUNDLE_WIDTH*BUNDLES-1:0] line_o,
    output logic      [AWID-1:0]                 line_adr_o,
    output logic      [ASID_WIDTH-1:0]           line_asid_o,
    output logic                                 err_o
);
    localparam int OFFS_BITS = $clog2(BUNDLE_WIDTH / 8);
    localparam int IDX_BITS  = $clog2(BUNDLES);
    localparam int LINE_OFFS = OFFS_BITS + IDX_BITS;

    icfill_state_t                 state_q;
    logic [IDX_BITS-1:0]           idx_q;
    logic [IDX_BITS-1:0]           cnt_q;
    logic [IDX_BITS-1:0]           crit_q;
    logic [AWID-LINE_OFFS-1:0]     line_tag_q;
    logic [ASID_WIDTH-1:0]         line_asid_q;
    logic                          crit_v_q;
    logic [BUNDLE_WIDTH-1:0]       crit_dat_q;
    logic                          err_q;

    logic [IDX_BITS-1:0]           w_miss_crit;
    logic [IDX_BITS-1:0]           w_start_idx;
    logic                          w_accept;
    logic                          w_beat_ok;
    logic                          w_buf_clr;
    logic                          w_unused;

    assign w_miss_crit = miss_adr_i[OFFS_BITS +: IDX_BITS];
    assign w_unused    = ^miss_adr_i[OFFS_BITS-1:0];

`ifdef THOR2024_ICFILL_CWF_EN
    assign w_start_idx = w_miss_crit;
`else
    assign w_start_idx = '0;
`endif

    assign w_accept  = (state_q == IDLE) && miss_i && !abort_i;
    assign w_beat_ok = (state_q == FETCH) && bus.ack && !bus.err && !abort_i;
    // Valid bits are dropped on a new miss and whenever a fill is abandoned.
    assign w_buf_clr = w_accept
                     || ((state_q == FETCH) && (abort_i || (bus.ack && bus.err)))
                     || ((state_q == COMMIT) && abort_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            crit_q      <= '0;
            line_tag_q  <= '0;
            line_asid_q <= '0;
            crit_v_q    <= 1'b0;
            crit_dat_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            crit_v_q <= 1'b0;
            err_q    <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (miss_i) begin
                            line_tag_q  <= miss_adr_i[AWID-1:LINE_OFFS];
                            line_asid_q <= miss_asid_i;
                            crit_q      <= w_miss_crit;
                            idx_q       <= w_start_idx;
                            cnt_q       <= '0;
                            state_q     <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (bus.ack && bus.err) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else if (bus.ack) begin
                            idx_q <= idx_q + IDX_BITS'(1);
                            cnt_q <= cnt_q + IDX_BITS'(1);
                            if (idx_q == crit_q) begin
                                crit_v_q   <= 1'b1;
                                crit_dat_q <= bus.dat;
                            end
                            if (cnt_q == IDX_BITS'(BUNDLES - 1)) begin
                                state_q <= COMMIT;
                            end
                        end
                    end
                    COMMIT:  state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    thor2024_bundle_buf #(
        .BUNDLE_WIDTH (BUNDLE_WIDTH),
        .BUNDLES      (BUNDLES)
    ) u_bundle_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_buf_clr),
        .wr_i    (w_beat_ok),
        .idx_i   (idx_q),
        .dat_i   (bus.dat),
        .line_o  (line_o),
        .valid_o (bundle_v_o)
    );

    assign ready_o     = (state_q == IDLE);
    assign bus.req     = (state_q == FETCH);
    assign bus.req_adr = {line_tag_q, idx_q, OFFS_BITS'(0)};
    assign crit_v_o    = crit_v_q;
    assign crit_dat_o  = crit_dat_q;
    assign line_wr_o   = (state_q == COMMIT) && !abort_i;
    assign line_adr_o  = {line_tag_q, LINE_OFFS'(0)};
    assign line_asid_o = line_asid_q;
    assign err_o       = err_q;
endmodule

`default_nettype wire

// File: tb/tb_thor2024_icache_line_fill.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_thor2024_icache_line_fill                               |
// | Brief   : scoreboard bench for the I-cache line-fill engine          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_thor2024_icache_line_fill;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int BW = 128;
    localparam int NB = 4;
    localparam int LW = BW * NB;
`ifdef THOR2024_ICFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_i;
    logic [AW-1:0] miss_adr_i;
    logic [SW-1:0] miss_asid_i;
    logic          abort_i;
    logic          ready_o;
    logic          crit_v_o;
    logic [BW-1:0] crit_dat_o;
    logic [NB-1:0] bundle_v_o;
    logic          line_wr_o;
    logic [LW-1:0] line_o;
    logic [AW-1:0] line_adr_o;
    logic [SW-1:0] line_asid_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] exp_adr_q  [$];
    logic [BW-1:0] exp_crit_q [$];
    logic [LW-1:0] exp_line_q [$];

    thor2024_icache_line_fill_if #(.AWID(AW), .BUNDLE_WIDTH(BW)) bus_if ();

    thor2024_icache_line_fill #(
        .AWID(AW), .ASID_WIDTH(SW), .BUNDLE_WIDTH(BW), .BUNDLES(NB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_i      (miss_i),
        .miss_adr_i  (miss_adr_i),
        .miss_asid_i (miss_asid_i),
        .abort_i     (abort_i),
        .ready_o     (ready_o),
        .bus         (bus_if.master),
        .crit_v_o    (crit_v_o),
        .crit_dat_o  (crit_dat_o),
        .bundle_v_o  (bundle_v_o),
        .line_wr_o   (line_wr_o),
        .line_o      (line_o),
        .line_adr_o  (line_adr_o),
        .line_asid_o (line_asid_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"},    ready_o,        1);
        chk({tag, "_req"},      bus_if.req,     0);
        chk({tag, "_req_adr"},  bus_if.req_adr, 0);
        chk({tag, "_crit_v"},   crit_v_o,       0);
        chk({tag, "_crit_dat"}, crit_dat_o,     0);
        chk({tag, "_bv"},       bundle_v_o,     0);
        chk({tag, "_wr"},       line_wr_o,      0);
        chk({tag, "_line"},     line_o,         0);
        chk({tag, "_ladr"},     line_adr_o,     0);
        chk({tag, "_asid"},     line_asid_o,    0);
        chk({tag, "_err"},      err_o,          0);
    endtask

    // err_beat / abort_beat: ack number (0-based) that carries the event, -1 for none.
    task automatic run_fill(input logic [AW-1:0] adr, input logic [SW-1:0] asid,
                            input int waits, input int err_beat, input int abort_beat);
        int crit, start, beat, wcnt, bidx, ncyc;
        int exp_crit_cyc, exp_wr_cyc, exp_err_cyc, abort_cyc;
        bit done, acked, wrote;
        logic [AW-1:0] base;
        logic [BW-1:0] dat;
        logic [LW-1:0] line_m;

        base  = {adr[AW-1:6], 6'b0};
        crit  = int'(adr[5:4]);
        start = CWF ? crit : 0;
        beat = 0; wcnt = 0; done = 0; wrote = 0; line_m = '0;
        exp_crit_cyc = -1; exp_wr_cyc = -1; exp_err_cyc = -1; abort_cyc = -1;
        ncyc = NB * (waits + 1) + 3;
        for (int b = 0; b < NB; b++)
            exp_adr_q.push_back(base + AW'(((start + b) % NB) * (BW / 8)));

        @(posedge clk); #1;
        miss_i = 1'b1; miss_adr_i = adr; miss_asid_i = asid;
        @(negedge clk);
        chk("ready_t0", ready_o, 1);

        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            miss_i = 1'b0; abort_i = 1'b0;
            bus_if.ack = 1'b0; bus_if.err = 1'b0;
            acked = 1'b0;
            if (bus_if.req && !done) begin
                if (wcnt == waits) begin
                    dat = {$urandom, $urandom, $urandom, $urandom};
                    bus_if.ack = 1'b1; bus_if.dat = dat;
                    acked = 1'b1; wcnt = 0;
                    bidx = (start + beat) % NB;
                    if (beat == err_beat) begin
                        bus_if.err = 1'b1; exp_err_cyc = c + 1; done = 1'b1;
                    end else if (beat == abort_beat) begin
                        abort_i = 1'b1; abort_cyc = c; done = 1'b1;
                    end else begin
                        line_m[bidx*BW +: BW] = dat;
                        if (bidx == crit) begin
                            exp_crit_q.push_back(dat);
                            exp_crit_cyc = c + 1;
                        end
                        if (beat == NB - 1) begin
                            exp_line_q.push_back(line_m);
                            exp_wr_cyc = c + 1;
                        end
                    end
                    beat++;
                end else begin
                    wcnt++;
                end
            end

            @(negedge clk);
            if (c == 1) chk("req_t1", bus_if.req, 1);
            if (bus_if.req) begin
                if (exp_adr_q.size() > 0) begin
                    chk("req_adr", bus_if.req_adr, exp_adr_q[0]);
                    if (acked) void'(exp_adr_q.pop_front());
                end else begin
                    chk("req_unexp", bus_if.req, 0);
                end
            end
            if (acked && done) exp_adr_q.delete();
            if (abort_cyc >= 0 && c == abort_cyc + 1) chk("req_post_abort", bus_if.req, 0);

            if (c == exp_crit_cyc) begin
                chk("crit_v", crit_v_o, 1);
                if (exp_crit_q.size() > 0) chk("crit_dat", crit_dat_o, exp_crit_q.pop_front());
            end else begin
                chk("crit_quiet", crit_v_o, 0);
            end

            if (c == exp_wr_cyc) begin
                chk("line_wr", line_wr_o, 1);
                chk("wr_lat", c, 1 + NB * (waits + 1));
                chk("line_bv", bundle_v_o, {NB{1'b1}});
                chk("line_adr", line_adr_o, base);
                chk("line_asid", line_asid_o, asid);
                if (exp_line_q.size() > 0) chk("line_dat", line_o, exp_line_q.pop_front());
                wrote = 1'b1;
            end else begin
                chk("wr_quiet", line_wr_o, 0);
            end

            if (c == exp_err_cyc) begin
                chk("err_pulse", err_o, 1);
                chk("err_bv", bundle_v_o, 0);
                chk("err_ready", ready_o, 1);
            end else begin
                chk("err_quiet", err_o, 0);
            end
        end

        chk("adr_left",  exp_adr_q.size(),  0);
        chk("crit_left", exp_crit_q.size(), 0);
        chk("line_left", exp_line_q.size(), 0);
        chk("end_ready", ready_o, 1);
        if (wrote) begin
            chk("hold_line", line_o, line_m);
            chk("hold_adr", line_adr_o, base);
        end
    endtask

    initial begin
        rst = 1'b1; miss_i = 1'b0; miss_adr_i = '0; miss_asid_i = '0; abort_i = 1'b0;
        bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.dat = '0;
        #1;
        chk_idle_outputs("rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run_fill(32'h0000_1234, 16'h0011, 0, -1, -1);
        run_fill(32'hABCD_EF70, 16'hBEEF, 0, -1, -1);
        run_fill(32'h0000_1234, 16'h0001, 0,  1, -1);
        run_fill(32'h0000_1234, 16'h0002, 0, -1,  2);
        run_fill(32'h0000_4458, 16'h0003, 3, -1, -1);

        // Asynchronous reset in the middle of a fill.
        @(posedge clk); #1;
        miss_i = 1'b1; miss_adr_i = 32'h0000_5678; miss_asid_i = 16'h00AA;
        @(posedge clk); #1;
        miss_i = 1'b0; bus_if.ack = 1'b1; bus_if.dat = {4{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        bus_if.ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        @(posedge clk); #2 rst = 1'b0;

        run_fill(32'h2000_0010, 16'h0004, 1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "bench timeout");
    end
endmodule

`default_nettype wire
